// File: rtl/bw_io_hstl_cal_ctl.sv
// HSTL driver calibration sequencer: holds drivers in por after reset, then slews
// cbu/cbd one LSB at a time toward handshaked targets, stepping only while pads are quiet.
module bw_io_hstl_cal_ctl #(
  parameter int unsigned POR_CYC    = 16,
  parameter int unsigned QUIET_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter logic [8:1]  CBU_RST    = 8'h80,
  parameter logic [8:1]  CBD_RST    = 8'h80
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       cal_vld,
  input  logic [8:1] cal_cbu,
  input  logic [8:1] cal_cbd,
  input  logic       drv_idle,
  output logic       cal_ack,
  output logic [8:1] cbu,
  output logic [8:1] cbd,
  output logic       por,
  output logic       upd_busy
);

  typedef enum logic [2:0] {
    StPorHold,
    StIdle,
    StWaitQuiet,
    StStep,
    StSettle
  } state_e;

  localparam logic [7:0] PorLast    = 8'(POR_CYC - 1);
  localparam logic [7:0] QuietLast  = 8'(QUIET_CYC - 1);
  localparam logic [7:0] SettleLast = 8'(SETTLE_CYC - 1);

  state_e     r_state, w_state_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [8:1] r_tgt_u, w_tgt_u_nxt;
  logic [8:1] r_tgt_d, w_tgt_d_nxt;
  logic [8:1] r_cbu, w_cbu_nxt;
  logic [8:1] r_cbd, w_cbd_nxt;
  logic       r_por, w_por_nxt;
  logic       w_at_tgt;

  assign w_at_tgt = (r_cbu == r_tgt_u) && (r_cbd == r_tgt_d);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tgt_u_nxt = r_tgt_u;
    w_tgt_d_nxt = r_tgt_d;
    w_cbu_nxt   = r_cbu;
    w_cbd_nxt   = r_cbd;
    w_por_nxt   = r_por;
    cal_ack     = 1'b0;
    case (r_state)
      StPorHold: begin
        if (r_cnt == PorLast) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 8'd0;
          w_por_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StIdle: begin
        if (cal_vld) begin
          cal_ack     = 1'b1;
          w_tgt_u_nxt = cal_cbu;
          w_tgt_d_nxt = cal_cbd;
          if ((cal_cbu != r_cbu) || (cal_cbd != r_cbd)) begin
            w_state_nxt = StWaitQuiet;
            w_cnt_nxt   = 8'd0;
          end
        end
      end
      StWaitQuiet: begin
        // Only an unbroken run of quiet cycles qualifies a step.
        if (!drv_idle) begin
          w_cnt_nxt = 8'd0;
        end else if (r_cnt == QuietLast) begin
          w_state_nxt = StStep;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      StStep: begin
        if (r_cbu < r_tgt_u) begin
          w_cbu_nxt = r_cbu + 8'd1;
        end else if (r_cbu > r_tgt_u) begin
          w_cbu_nxt = r_cbu - 8'd1;
        end
        if (r_cbd < r_tgt_d) begin
          w_cbd_nxt = r_cbd + 8'd1;
        end else if (r_cbd > r_tgt_d) begin
          w_cbd_nxt = r_cbd - 8'd1;
        end
        w_state_nxt = StSettle;
        w_cnt_nxt   = 8'd0;
      end
      StSettle: begin
        if (r_cnt == SettleLast) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = w_at_tgt ? StIdle : StWaitQuiet;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = StPorHold;
        w_cnt_nxt   = 8'd0;
        w_por_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state <= StPorHold;
      r_cnt   <= 8'd0;
      r_tgt_u <= CBU_RST;
      r_tgt_d <= CBD_RST;
      r_cbu   <= CBU_RST;
      r_cbd   <= CBD_RST;
      r_por   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tgt_u <= w_tgt_u_nxt;
      r_tgt_d <= w_tgt_d_nxt;
      r_cbu   <= w_cbu_nxt;
      r_cbd   <= w_cbd_nxt;
      r_por   <= w_por_nxt;
    end
  end

  assign cbu      = r_cbu;
  assign cbd      = r_cbd;
  assign por      = r_por;
  assign upd_busy = (r_state == StWaitQuiet) || (r_state == StStep) || (r_state == StSettle);

endmodule
